// File: rtl/c2s_slave.sv
// c2s_slave: consumer side of the C2S call channel.
// Runs a req/ack request as beats on a valid/ready register bus.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   req              request level (async, synchronised here)
//   id, fn, addr     packet header, stable while req=1
//   data             DATA_SIZE packed words, word i at [32*i +: 32]
//   ack              completion acknowledge
//   ret              signed result, valid while ack=1
//   last_id          id of the last completed packet
//   bus_valid        beat request
//   bus_write        1=write beat, 0=read beat
//   bus_addr         beat byte address
//   bus_wdata        write data
//   bus_ready        beat accepted (read data valid same cycle)
//   bus_rdata        read data
module c2s_slave #(
   parameter int DATA_SIZE = 4,
   parameter int TIMEOUT   = 1024,
   parameter int ADDR_STEP = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req,
   input  logic [31:0]             id,
   input  logic [31:0]             fn,
   input  logic [31:0]             addr,
   input  logic [32*DATA_SIZE-1:0] data,
   output logic                    ack,
   output logic [31:0]             ret,
   output logic [31:0]             last_id,
   output logic                    bus_valid,
   output logic                    bus_write,
   output logic [31:0]             bus_addr,
   output logic [31:0]             bus_wdata,
   input  logic                    bus_ready,
   input  logic [31:0]             bus_rdata
);

   localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_SIZE - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
   localparam logic [31:0]   STEP     = 32'(ADDR_STEP);

   localparam logic [31:0] FN_NOP = 32'd0;
   localparam logic [31:0] FN_WR  = 32'd1;
   localparam logic [31:0] FN_RD  = 32'd2;

   localparam logic [31:0] RET_OK  = 32'h0000_0000;
   localparam logic [31:0] RET_BAD = 32'hFFFF_FFFF;
   localparam logic [31:0] RET_TO  = 32'hFFFF_FFFE;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_BUS,
      S_RESP,
      S_WAIT_REL
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [31:0]   id_q, id_d;
   logic [31:0]   fn_q, fn_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q [DATA_SIZE];
   logic [31:0]   data_d [DATA_SIZE];
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   ret_q, ret_d;
   logic          ack_q, ack_d;
   logic [31:0]   last_id_q, last_id_d;

   logic req_s;
   logic is_nop;
   logic is_wr;
   logic is_rd;

   assign req_s  = sync_q[1];
   assign is_nop = (fn_q == FN_NOP);
   assign is_wr  = (fn_q == FN_WR);
   assign is_rd  = (fn_q == FN_RD);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sync_q    <= '0;
         id_q      <= '0;
         fn_q      <= '0;
         addr_q    <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         ret_q     <= '0;
         ack_q     <= 1'b0;
         last_id_q <= '0;
         for (int i = 0; i < DATA_SIZE; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         id_q      <= id_d;
         fn_q      <= fn_d;
         addr_q    <= addr_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         ret_q     <= ret_d;
         ack_q     <= ack_d;
         last_id_q <= last_id_d;
         for (int i = 0; i < DATA_SIZE; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      sync_d    = {sync_q[0], req};
      id_d      = id_q;
      fn_d      = fn_q;
      addr_d    = addr_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      ret_d     = ret_q;
      ack_d     = ack_q;
      last_id_d = last_id_q;
      for (int i = 0; i < DATA_SIZE; i++) begin
         data_d[i] = data_q[i];
      end

      unique case (state_q)
         S_IDLE: begin
            if (req_s) begin
               id_d   = id;
               fn_d   = fn;
               addr_d = addr;
               for (int i = 0; i < DATA_SIZE; i++) begin
                  data_d[i] = data[32*i +: 32];
               end
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            idx_d = '0;
            cnt_d = '0;
            unique case (1'b1)
               is_nop: begin
                  ret_d   = RET_OK;
                  state_d = S_RESP;
               end
               is_wr, is_rd: begin
                  state_d = S_BUS;
               end
               default: begin
                  ret_d   = RET_BAD;
                  state_d = S_RESP;
               end
            endcase
         end

         S_BUS: begin
            // addr_q doubles as the running beat address.
            // A ready in the last allowed cycle still wins
            // over the timeout.
            if (bus_ready) begin
               cnt_d = '0;
               if (is_rd) begin
                  ret_d   = bus_rdata;
                  state_d = S_RESP;
               end else if (idx_q == LAST_IDX) begin
                  ret_d   = RET_OK;
                  state_d = S_RESP;
               end else begin
                  idx_d  = idx_q + IW'(1);
                  addr_d = addr_q + STEP;
               end
            end else if (cnt_q == TO_LAST) begin
               ret_d   = RET_TO;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_RESP: begin
            ack_d     = 1'b1;
            last_id_d = id_q;
            state_d   = S_WAIT_REL;
         end

         S_WAIT_REL: begin
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs; bus signals are forced to 0 outside BUS
   always_comb begin
      bus_valid = 1'b0;
      bus_write = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      if (state_q == S_BUS) begin
         bus_valid = 1'b1;
         bus_write = is_wr;
         bus_addr  = addr_q;
         if (is_wr) begin
            bus_wdata = data_q[idx_q];
         end
      end
      ack     = ack_q;
      ret     = ret_q;
      last_id = last_id_q;
   end

endmodule
